fft_seq_ctrl: RTL and testbench

- Parametrised sequencer for an in-place radix-2 DIF FFT built from a single butterfly and a simple dual-port RAM.
- Generalises the fixed 16-point read/write controllers and the fixed 3-cycle write-start delay to N = 2^LOGN points, any butterfly latency, and ping-pong banks per stage.
- Adds twiddle-index generation and a bit-reversed output readout with ready-based flow control.
- Sits between the RAM (read port B, write port A) and the butterfly datapath.

---
 rtl/fft_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// Address/enable sequencer for an in-place radix-2 DIF FFT: one butterfly, one
// simple dual-port RAM, ping-pong banks per stage, and a bit-reversed readout.
module fft_seq_ctrl #(
  parameter int LOGN   = 4,
  parameter int BF_LAT = 3,
  parameter int STW    = 4
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iSTART,
  input  logic            iCLR,
  input  logic            iOUT_RDY,
  output logic            oBUSY,
  output logic            oDONE,
  output logic            oRD_EN,
  output logic [LOGN:0]   oRADDR,
  output logic            oBF_EN,
  output logic            oBF_SEL,
  output logic [LOGN-2:0] oTW_IDX,
  output logic            oWR_EN,
  output logic [LOGN:0]   oWADDR,
  output logic [STW-1:0]  oSTAGE,
  output logic            oOUT_VALID
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN-1:0] LASTCNT = LOGN'(N - 1);
  localparam logic [STW-1:0] LASTSTG = STW'(LOGN - 1);
  localparam logic [3:0] DRAINEND = 4'(BF_LAT);
  localparam logic OUTBANK = 1'(LOGN % 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COMP  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } stateT;

  stateT           state, stateNxt;
  logic [LOGN-1:0] cnt, cntNxt;
  logic [STW-1:0]  stg, stgNxt;
  logic [3:0]      drn, drnNxt;

  // Per-read side information travelling one cycle behind oRD_EN.
  logic            rdComp, rdOut, selR;
  logic [LOGN-2:0] twR;
  logic            wrEnPipe [BF_LAT:0];
  logic [LOGN:0]   wrAddrPipe [BF_LAT:0];

  logic            rdEnNxt, rdCompNxt, rdOutNxt, selNxt, busyNxt, doneNxt;
  logic [LOGN:0]   raddrNxt;
  logic [LOGN-2:0] twNxt;
  logic [STW-1:0]  stageNxt;

  logic [LOGN-1:0] pW, lowW, highW, idxS, twW;
  int              sh;

  function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = v[LOGN-1-i];
    end
    return r;
  endfunction

  // Butterfly pair addressing: sel is spliced into p at bit LOGN-1-stage.
  always_comb begin
    sh    = LOGN - 1 - int'(stg);
    pW    = {1'b0, cnt[LOGN-1:1]};
    lowW  = pW & ((LOGN'(1'b1) << sh) - LOGN'(1'b1));
    highW = pW >> sh;
    idxS  = (highW << (sh + 1)) | (LOGN'(cnt[0]) << sh) | lowW;
    twW   = lowW << stg;
  end

  // Next-state and next-output decode.
  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    stgNxt    = stg;
    drnNxt    = drn;
    rdEnNxt   = 1'b0;
    raddrNxt  = {(LOGN+1){1'b0}};
    rdCompNxt = 1'b0;
    rdOutNxt  = 1'b0;
    selNxt    = 1'b0;
    twNxt     = {(LOGN-1){1'b0}};
    busyNxt   = 1'b1;
    doneNxt   = 1'b0;
    stageNxt  = stg;
    case (state)
      ST_IDLE: begin
        busyNxt  = 1'b0;
        stageNxt = {STW{1'b0}};
        if (iSTART) begin
          stateNxt = ST_COMP;
          cntNxt   = {LOGN{1'b0}};
          stgNxt   = {STW{1'b0}};
          drnNxt   = 4'd0;
        end else begin
          stateNxt = ST_IDLE;
        end
      end
      ST_COMP: begin
        rdEnNxt   = 1'b1;
        rdCompNxt = 1'b1;
        raddrNxt  = {stg[0], idxS};
        selNxt    = cnt[0];
        twNxt     = twW[LOGN-2:0];
        cntNxt    = cnt + LOGN'(1'b1);
        if (cnt == LASTCNT) begin
          stateNxt = ST_DRAIN;
          cntNxt   = {LOGN{1'b0}};
          drnNxt   = 4'd0;
        end else begin
          stateNxt = ST_COMP;
        end
      end
      // The last write of the stage leaves the pipe on the cycle drn hits BF_LAT.
      ST_DRAIN: begin
        if (drn == DRAINEND) begin
          drnNxt = 4'd0;
          if (stg == LASTSTG) begin
            stateNxt = ST_OUT;
          end else begin
            stgNxt   = stg + STW'(1'b1);
            stateNxt = ST_COMP;
          end
        end else begin
          drnNxt = drn + 4'd1;
        end
      end
      ST_OUT: begin
        if (iOUT_RDY) begin
          rdEnNxt  = 1'b1;
          rdOutNxt = 1'b1;
          raddrNxt = {OUTBANK, bitRev(cnt)};
          cntNxt   = cnt + LOGN'(1'b1);
          if (cnt == LASTCNT) begin
            stateNxt = ST_DONE;
            cntNxt   = {LOGN{1'b0}};
          end else begin
            stateNxt = ST_OUT;
          end
        end else begin
          stateNxt = ST_OUT;
        end
      end
      ST_DONE: begin
        doneNxt  = 1'b1;
        stateNxt = ST_IDLE;
      end
      default: begin
        busyNxt  = 1'b0;
        stateNxt = ST_IDLE;
      end
    endcase
  end

  // State, counters, output registers and the write delay line.
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      state      <= ST_IDLE;
      cnt        <= {LOGN{1'b0}};
      stg        <= {STW{1'b0}};
      drn        <= 4'd0;
      rdComp     <= 1'b0;
      rdOut      <= 1'b0;
      selR       <= 1'b0;
      twR        <= {(LOGN-1){1'b0}};
      oRD_EN     <= 1'b0;
      oRADDR     <= {(LOGN+1){1'b0}};
      oBF_EN     <= 1'b0;
      oBF_SEL    <= 1'b0;
      oTW_IDX    <= {(LOGN-1){1'b0}};
      oOUT_VALID <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oSTAGE     <= {STW{1'b0}};
      for (int i = 0; i <= BF_LAT; i++) begin
        wrEnPipe[i]   <= 1'b0;
        wrAddrPipe[i] <= {(LOGN+1){1'b0}};
      end
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      stg        <= stgNxt;
      drn        <= drnNxt;
      rdComp     <= rdCompNxt;
      rdOut      <= rdOutNxt;
      selR       <= selNxt;
      twR        <= twNxt;
      oRD_EN     <= rdEnNxt;
      oRADDR     <= raddrNxt;
      oBF_EN     <= rdComp;
      oBF_SEL    <= selR;
      oTW_IDX    <= twR;
      oOUT_VALID <= rdOut;
      oBUSY      <= busyNxt;
      oDONE      <= doneNxt;
      oSTAGE     <= stageNxt;
      wrEnPipe[0]   <= rdComp;
      wrAddrPipe[0] <= rdComp ? {~oRADDR[LOGN], oRADDR[LOGN-1:0]} : {(LOGN+1){1'b0}};
      for (int i = 1; i <= BF_LAT; i++) begin
        wrEnPipe[i]   <= wrEnPipe[i-1];
        wrAddrPipe[i] <= wrAddrPipe[i-1];
      end
    end
  end

  assign oWR_EN = wrEnPipe[BF_LAT];
  assign oWADDR = wrAddrPipe[BF_LAT];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: expected RAM/butterfly events are derived
// from the FFT addressing rules and checked by a negedge monitor.
module tb_fft_seq_ctrl;
  localparam int LOGN = 4;
  localparam int BF_LAT = 3;
  localparam int STW = 4;
  localparam int N = 1 << LOGN;
  localparam int P = N + BF_LAT + 1;
  localparam int OUTBANK = LOGN % 2;

  logic clk = 1'b0;
  logic iRST, iSTART, iCLR, iOUT_RDY;
  logic oBUSY, oDONE, oRD_EN, oBF_EN, oBF_SEL, oWR_EN, oOUT_VALID;
  logic [LOGN:0] oRADDR, oWADDR;
  logic [LOGN-2:0] oTW_IDX;
  logic [STW-1:0] oSTAGE;
  logic [31:0] allOuts;

  fft_seq_ctrl #(.LOGN(LOGN), .BF_LAT(BF_LAT), .STW(STW)) dut (
    .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iCLR(iCLR), .iOUT_RDY(iOUT_RDY),
    .oBUSY(oBUSY), .oDONE(oDONE), .oRD_EN(oRD_EN), .oRADDR(oRADDR),
    .oBF_EN(oBF_EN), .oBF_SEL(oBF_SEL), .oTW_IDX(oTW_IDX), .oWR_EN(oWR_EN),
    .oWADDR(oWADDR), .oSTAGE(oSTAGE), .oOUT_VALID(oOUT_VALID)
  );

  assign allOuts = 32'({oBUSY, oDONE, oRD_EN, oRADDR, oBF_EN, oBF_SEL, oTW_IDX,
                        oWR_EN, oWADDR, oSTAGE, oOUT_VALID});

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int val; int aux;} evT;
  evT rdQ[$];
  evT bfQ[$];
  evT wrQ[$];
  evT valQ[$];

  int checks = 0;
  int errors = 0;
  bit monEn = 1'b0;
  int busyFrom = 1000000;
  int busyTo = -1;
  int doneCyc = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Pair index: sel goes in at bit LOGN-1-s, p's high s bits move above it.
  function automatic int refIdx(input int s, input int c);
    int p, lowBits, lo, hi;
    p = c / 2;
    lowBits = LOGN - 1 - s;
    lo = p % (1 << lowBits);
    hi = p / (1 << lowBits);
    return hi * (1 << (lowBits + 1)) + (c % 2) * (1 << lowBits) + lo;
  endfunction

  function automatic int refTw(input int s, input int c);
    int lo;
    lo = (c / 2) % (1 << (LOGN - 1 - s));
    return (lo * (1 << s)) % (1 << (LOGN - 1));
  endfunction

  function automatic int bitrevI(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCompute(input int S);
    int r, idx;
    for (int s = 0; s < LOGN; s++) begin
      for (int c = 0; c < N; c++) begin
        r = S + 1 + s * P + c;
        idx = refIdx(s, c);
        rdQ.push_back('{r, (s % 2) * N + idx, s});
        bfQ.push_back('{r + 1, c % 2, refTw(s, c)});
        wrQ.push_back('{r + BF_LAT + 1, (1 - s % 2) * N + idx, 0});
      end
    end
  endtask

  task automatic prune(input int lim);
    for (int i = rdQ.size() - 1; i >= 0; i--) if (rdQ[i].cyc >= lim) rdQ.delete(i);
    for (int i = bfQ.size() - 1; i >= 0; i--) if (bfQ[i].cyc >= lim) bfQ.delete(i);
    for (int i = wrQ.size() - 1; i >= 0; i--) if (wrQ[i].cyc >= lim) wrQ.delete(i);
    for (int i = valQ.size() - 1; i >= 0; i--) if (valQ[i].cyc >= lim) valQ.delete(i);
  endtask

  task automatic startRun(output int S);
    iSTART = 1'b1;
    S = cyc + 1;
    pushCompute(S);
    busyFrom = S + 1;
    busyTo = 1000000;
    doneCyc = -1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic runFull(input bit pulses);
    int S, k, outStart, e, guard;
    startRun(S);
    outStart = S + LOGN * P + 1;
    k = 0;
    guard = 0;
    while (doneCyc < 0 || cyc < doneCyc + 2) begin
      e = cyc + 1;
      iSTART = (pulses && e < outStart) ? 1'($urandom_range(0, 1)) : 1'b0;
      iOUT_RDY = ($urandom_range(0, 2) != 0);
      if (e >= outStart && k < N) begin
        guard++;
        if (guard > 3 * N) iOUT_RDY = 1'b1;
        if (iOUT_RDY) begin
          rdQ.push_back('{e, OUTBANK * N + bitrevI(k), LOGN - 1});
          valQ.push_back('{e + 1, 0, 0});
          if (k == N - 1) begin
            doneCyc = e + 1;
            busyTo = e + 1;
          end
          k++;
        end
      end
      tick();
    end
    iSTART = 1'b0;
    iOUT_RDY = 1'b0;
  endtask

  task automatic runAbort(input bit useRst, input int off, input int len);
    int S, R;
    startRun(S);
    iOUT_RDY = 1'b1;
    while (cyc + 1 < S + off) tick();
    R = cyc + 1;
    prune(R);
    busyTo = R - 1;
    if (useRst) iRST = 1'b1;
    else iCLR = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      chk(useRst ? "rst_outputs_zero" : "clr_outputs_zero", allOuts, 32'd0);
    end
    iRST = 1'b0;
    iCLR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_write_after_abort", oWR_EN, 32'd0);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    evT e;
    if (monEn) begin
      if (oRD_EN === 1'b1) begin
        if (rdQ.size() == 0) chk("rd_unexpected", oRD_EN, 32'd0);
        else begin
          e = rdQ.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", oRADDR, e.val);
          chk("rd_stage", oSTAGE, e.aux);
        end
      end else if (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
        chk("rd_missing", oRD_EN, 32'd1);
        void'(rdQ.pop_front());
      end
      if (oBF_EN === 1'b1) begin
        if (bfQ.size() == 0) chk("bf_unexpected", oBF_EN, 32'd0);
        else begin
          e = bfQ.pop_front();
          chk("bf_cycle", cyc, e.cyc);
          chk("bf_sel", oBF_SEL, e.val);
          chk("tw_idx", oTW_IDX, e.aux);
        end
      end else begin
        chk("bf_idle_zero", {oBF_SEL, oTW_IDX}, 32'd0);
        if (bfQ.size() > 0 && bfQ[0].cyc <= cyc) begin
          chk("bf_missing", oBF_EN, 32'd1);
          void'(bfQ.pop_front());
        end
      end
      if (oWR_EN === 1'b1) begin
        if (wrQ.size() == 0) chk("wr_unexpected", oWR_EN, 32'd0);
        else begin
          e = wrQ.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", oWADDR, e.val);
        end
      end else if (wrQ.size() > 0 && wrQ[0].cyc <= cyc) begin
        chk("wr_missing", oWR_EN, 32'd1);
        void'(wrQ.pop_front());
      end
      if (oOUT_VALID === 1'b1) begin
        if (valQ.size() == 0) chk("valid_unexpected", oOUT_VALID, 32'd0);
        else begin
          e = valQ.pop_front();
          chk("valid_cycle", cyc, e.cyc);
        end
      end else if (valQ.size() > 0 && valQ[0].cyc <= cyc) begin
        chk("valid_missing", oOUT_VALID, 32'd1);
        void'(valQ.pop_front());
      end
      chk("done", oDONE, 32'(cyc == doneCyc));
      chk("busy", oBUSY, 32'(cyc >= busyFrom && cyc <= busyTo));
    end
  end

  initial begin
    iRST = 1'b1;
    iSTART = 1'b0;
    iCLR = 1'b0;
    iOUT_RDY = 1'b0;
    repeat (3) tick();
    chk("reset_outputs_zero", allOuts, 32'd0);
    monEn = 1'b1;
    iRST = 1'b0;
    tick();
    runFull(1'b1);
    runAbort(1'b1, P + 5, 3);
    runAbort(1'b0, 2 * P + 7, 1);
    runFull(1'b0);
    runFull(1'b1);
    repeat (3) tick();
    chk("rd_queue_drained", rdQ.size(), 32'd0);
    chk("wr_queue_drained", wrQ.size(), 32'd0);
    chk("valid_queue_drained", valQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
